// File: rtl/rd_return_ctrl.sv
// rd_return_ctrl: credit-gated read command admission plus a skid buffer that
// absorbs non-stallable PHY read beats and forwards them into the read-data FIFO.
// Optional build macro RD_RETURN_TIMEOUT_EN adds a return-timeout watchdog and
// the tmo_err_o port.
module rd_return_ctrl #(
  parameter int DATA_W     = 64,
  parameter int LEN_W      = 4,
  parameter int CREDITS    = 256,
  parameter int CRD_W      = 9,
  parameter int SKID_DEPTH = 4,
  parameter int TMO_W      = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic              cmd_ready_o,
  output logic              phy_cmd_valid_o,
  output logic [LEN_W-1:0]  phy_cmd_len_o,
  input  logic              phy_cmd_ready_i,
  input  logic              rd_valid_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              fifo_wr_o,
  output logic [DATA_W-1:0] fifo_data_o,
  input  logic              fifo_wr_ready_i,
  input  logic              fifo_pop_i,
  output logic [CRD_W-1:0]  credits_o,
  output logic [CRD_W-1:0]  outstanding_o,
  output logic              ovf_err_o
`ifdef RD_RETURN_TIMEOUT_EN
  ,
  output logic              tmo_err_o
`endif
);

  localparam int AW = $clog2(SKID_DEPTH);
  localparam logic [CRD_W-1:0] CRD_MAX   = CRD_W'(CREDITS);
  localparam logic [CRD_W:0]   CRD_MAX_X = (CRD_W+1)'(CREDITS);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [CRD_W-1:0]   r_credits;
  logic [CRD_W-1:0]   r_out;
  logic               r_ovf;

  logic [DATA_W-1:0]  r_mem [SKID_DEPTH];
  logic [AW:0]        r_wptr;
  logic [AW:0]        r_rptr;

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_skid_wr;
  logic               w_drop;
  logic [CRD_W-1:0]   w_acc_len;
  logic               w_pop_ok;
  logic               w_pop_ovf;
  logic               w_out_dec;
  logic               w_push_ovf;
  logic               w_tmo_fire;
  logic [CRD_W-1:0]   w_ret;
  logic [CRD_W:0]     w_crd_sum;
  logic [CRD_W-1:0]   w_crd_nxt;
  logic [CRD_W-1:0]   w_out_nxt;

  // Skid buffer status and handshake qualifiers
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) &&
                      (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push     = !w_empty && fifo_wr_ready_i;
  // A write into a full buffer is fine when the head leaves in the same cycle
  assign w_skid_wr  = rd_valid_i && (!w_full || w_push);
  assign w_drop     = rd_valid_i && w_full && !w_push;

  assign fifo_wr_o   = !w_empty;
  assign fifo_data_o = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  // Command FSM: next state and handshake outputs
  always_comb begin
    w_state_nxt     = r_state;
    cmd_ready_o     = 1'b0;
    phy_cmd_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid_i && (cmd_len_i != '0) &&
            (r_credits >= {{(CRD_W-LEN_W){1'b0}}, cmd_len_i})) begin
          cmd_ready_o = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        phy_cmd_valid_o = 1'b1;
        if (phy_cmd_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_acc_len  = cmd_ready_o ? {{(CRD_W-LEN_W){1'b0}}, cmd_len_i} : '0;
  // A credit return when already full would overflow the pool; drop and flag it
  assign w_pop_ok   = fifo_pop_i && (r_credits != CRD_MAX);
  assign w_pop_ovf  = fifo_pop_i && (r_credits == CRD_MAX);
  assign w_out_dec  = w_push && (r_out != '0);
  assign w_push_ovf = w_push && (r_out == '0);

`ifdef RD_RETURN_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo;
  logic             r_tmo_err;

  assign w_tmo_fire = (r_out != '0) && (r_tmo == '1) && !rd_valid_i;
  // Beats that will never arrive go back to the pool (minus one pushed now)
  assign w_ret      = w_tmo_fire ? (r_out - {{(CRD_W-1){1'b0}}, w_out_dec}) : '0;
  assign tmo_err_o  = r_tmo_err;

  // Watchdog: counts idle cycles while beats are owed, restarts on every beat
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tmo     <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (rd_valid_i || (r_out == '0) || w_tmo_fire) r_tmo <= '0;
      else                                            r_tmo <= r_tmo + 1'b1;
      if (w_tmo_fire) r_tmo_err <= 1'b1;
    end
  end
`else
  assign w_tmo_fire = 1'b0;
  assign w_ret      = '0;
`endif

  // Credit and outstanding-beat arithmetic, saturating credits at the pool size
  always_comb begin
    w_crd_sum = {1'b0, r_credits} - {1'b0, w_acc_len}
              + {{CRD_W{1'b0}}, w_pop_ok} + {1'b0, w_ret};
    w_crd_nxt = (w_crd_sum > CRD_MAX_X) ? CRD_MAX : w_crd_sum[CRD_W-1:0];
    if (w_tmo_fire) w_out_nxt = w_acc_len;
    else            w_out_nxt = r_out + w_acc_len - {{(CRD_W-1){1'b0}}, w_out_dec};
  end

  // Control state: FSM, latched length, counters, skid pointers, sticky error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_credits <= CRD_MAX;
      r_out     <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      if (cmd_ready_o) r_len <= cmd_len_i;
      r_credits <= w_crd_nxt;
      r_out     <= w_out_nxt;
      if (w_skid_wr) r_wptr <= r_wptr + 1'b1;
      if (w_push)    r_rptr <= r_rptr + 1'b1;
      if (w_drop || w_pop_ovf || w_push_ovf) r_ovf <= 1'b1;
    end
  end

  // Skid storage: data only, no reset needed
  always_ff @(posedge clk_i) begin
    if (w_skid_wr) r_mem[r_wptr[AW-1:0]] <= rd_data_i;
  end

  assign phy_cmd_len_o = r_len;
  assign credits_o     = r_credits;
  assign outstanding_o = r_out;
  assign ovf_err_o     = r_ovf;

endmodule

// File: tb/tb_rd_return_ctrl.sv
// Directed, table-driven bench for rd_return_ctrl with hand-written sequences
// for the multi-cycle cases (backpressure, overflow, credit exhaustion, reset).
module tb_rd_return_ctrl;

  logic        clk = 1'b0;
  logic        rst, cv, pr, rv, wr_rdy, pop;
  logic [3:0]  len;
  logic [63:0] rd;
  logic        rdy, pv, fwr, ovf;
  logic [3:0]  plen;
  logic [63:0] fdata;
  logic [8:0]  crd, outs;
`ifdef RD_RETURN_TIMEOUT_EN
  logic        tmo;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic [63:0] got[$];

  always #5 clk = ~clk;

  rd_return_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cv), .cmd_len_i(len), .cmd_ready_o(rdy),
    .phy_cmd_valid_o(pv), .phy_cmd_len_o(plen), .phy_cmd_ready_i(pr),
    .rd_valid_i(rv), .rd_data_i(rd),
    .fifo_wr_o(fwr), .fifo_data_o(fdata), .fifo_wr_ready_i(wr_rdy),
    .fifo_pop_i(pop), .credits_o(crd), .outstanding_o(outs), .ovf_err_o(ovf)
`ifdef RD_RETURN_TIMEOUT_EN
    , .tmo_err_o(tmo)
`endif
  );

  // Record every beat the FIFO accepts
  always @(negedge clk) if (fwr && wr_rdy) got.push_back(fdata);

  typedef struct {
    logic rst; logic cv; logic [3:0] len; logic pr; logic rv; logic [63:0] rd;
    logic wr; logic pop;
    logic e_rdy; logic e_pv; logic [3:0] e_len; logic e_wr; logic [63:0] e_data;
    logic [8:0] e_crd; logic [8:0] e_out; logic e_ovf;
  } vec_t;
  vec_t tv[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    cv = 0; len = 0; pr = 0; rv = 0; rd = 0; wr_rdy = 0; pop = 0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1; tick(); rst = 0;
  endtask

  task automatic issue_cmd(input logic [3:0] l);
    cv = 1; len = l; pr = 1;
    @(negedge clk); check("issue_rdy", rdy, 1);
    tick(); cv = 0;
    @(negedge clk); tick(); pr = 0;
  endtask

  initial begin
    idle_inputs(); rst = 1;
    tick(); tick();

    //            rst cv len pr rv rd     wr pop | rdy pv plen wr data   crd  out ovf
    tv[0]  = '{1, 0, 0, 0, 0, 64'h0,  0, 0,   0, 0, 0, 0, 64'h0,  256, 0,  0};
    tv[1]  = '{0, 1, 8, 0, 0, 64'h0,  0, 0,   1, 0, 0, 0, 64'h0,  256, 0,  0};
    tv[2]  = '{0, 0, 0, 0, 0, 64'h0,  0, 0,   0, 1, 8, 0, 64'h0,  248, 8,  0};
    tv[3]  = '{0, 1, 3, 0, 0, 64'h0,  0, 0,   0, 1, 8, 0, 64'h0,  248, 8,  0};
    tv[4]  = '{0, 0, 0, 1, 0, 64'h0,  0, 0,   0, 1, 8, 0, 64'h0,  248, 8,  0};
    tv[5]  = '{0, 1, 2, 0, 0, 64'h0,  0, 1,   1, 0, 8, 0, 64'h0,  248, 8,  0};
    tv[6]  = '{0, 0, 0, 1, 1, 64'h11, 1, 0,   0, 1, 2, 0, 64'h0,  247, 10, 0};
    tv[7]  = '{0, 0, 0, 0, 1, 64'h22, 1, 0,   0, 0, 2, 1, 64'h11, 247, 10, 0};
    tv[8]  = '{0, 0, 0, 0, 0, 64'h0,  0, 0,   0, 0, 2, 1, 64'h22, 247, 9,  0};
    tv[9]  = '{0, 0, 0, 0, 0, 64'h0,  1, 0,   0, 0, 2, 1, 64'h22, 247, 9,  0};
    tv[10] = '{0, 0, 0, 0, 0, 64'h0,  0, 0,   0, 0, 2, 0, 64'h0,  247, 8,  0};

    for (int i = 0; i < 11; i++) begin
      rst = tv[i].rst; cv = tv[i].cv; len = tv[i].len; pr = tv[i].pr;
      rv = tv[i].rv; rd = tv[i].rd; wr_rdy = tv[i].wr; pop = tv[i].pop;
      @(negedge clk);
      check($sformatf("v%0d_rdy", i),  rdy,   tv[i].e_rdy);
      check($sformatf("v%0d_pv", i),   pv,    tv[i].e_pv);
      check($sformatf("v%0d_plen", i), plen,  tv[i].e_len);
      check($sformatf("v%0d_wr", i),   fwr,   tv[i].e_wr);
      check($sformatf("v%0d_data", i), fdata, tv[i].e_data);
      check($sformatf("v%0d_crd", i),  crd,   tv[i].e_crd);
      check($sformatf("v%0d_out", i),  outs,  tv[i].e_out);
      check($sformatf("v%0d_ovf", i),  ovf,   tv[i].e_ovf);
      tick();
    end
    idle_inputs();

    // Return stream with backpressure: 8 beats owed, ready low in cycles 2-4
    got.delete();
    for (int c = 1; c <= 10; c++) begin
      rv = (c <= 8); rd = 64'(c); wr_rdy = !(c >= 2 && c <= 4);
      @(negedge clk); tick();
    end
    rv = 0; rd = 0; wr_rdy = 1;
    for (int c = 0; c < 10; c++) begin @(negedge clk); tick(); end
    wr_rdy = 0;
    check("bp_count", 64'(got.size()), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("bp_beat%0d", i), (i < got.size()) ? got[i] : 64'hdead, 64'(i + 1));
    @(negedge clk);
    check("bp_out", outs, 0);
    check("bp_ovf", ovf, 0);
    check("bp_crd", crd, 247);
    tick();

    // Overflow: five beats into a 4-deep skid with the FIFO stalled
    do_reset(); got.delete();
    for (int i = 1; i <= 5; i++) begin
      rv = 1; rd = 64'hA0 + 64'(i);
      @(negedge clk);
      if (i == 5) check("ovf_before5", ovf, 0);
      tick();
    end
    rv = 0; rd = 0;
    @(negedge clk); check("ovf_set", ovf, 1); tick();
    tick(); tick();
    @(negedge clk); check("ovf_sticky", ovf, 1); tick();
    wr_rdy = 1;
    for (int c = 0; c < 6; c++) begin @(negedge clk); tick(); end
    wr_rdy = 0;
    check("ovf_count", 64'(got.size()), 4);
    check("ovf_last", (got.size() == 4) ? got[3] : 64'hdead, 64'hA4);
    @(negedge clk); check("ovf_after_drain", ovf, 1); tick();
    do_reset();
    @(negedge clk); check("ovf_cleared", ovf, 0); tick();

    // Credit return while the pool is already full
    pop = 1; tick(); pop = 0;
    @(negedge clk);
    check("popfull_crd", crd, 256);
    check("popfull_ovf", ovf, 1);
    tick();

    // Credit exhaustion: drain to 3 credits, len=4 waits for one pop
    do_reset();
    for (int i = 0; i < 16; i++) issue_cmd(4'd15);
    issue_cmd(4'd13);
    @(negedge clk); check("exh_crd3", crd, 3); tick();
    cv = 1; len = 4; pr = 1;
    @(negedge clk); check("exh_block0", rdy, 0); tick();
    @(negedge clk); check("exh_block1", rdy, 0); tick();
    pop = 1;
    @(negedge clk); check("exh_block_pop", rdy, 0); tick();
    pop = 0;
    @(negedge clk);
    check("exh_crd4", crd, 4);
    check("exh_accept", rdy, 1);
    tick(); cv = 0;
    @(negedge clk);
    check("exh_crd0", crd, 0);
    check("exh_pv", pv, 1);
    tick(); pr = 0;

    // Simultaneous accept len=2 and pop at 10 credits
    do_reset();
    for (int i = 0; i < 16; i++) issue_cmd(4'd15);
    issue_cmd(4'd6);
    @(negedge clk); check("sim_crd10", crd, 10); tick();
    cv = 1; len = 2; pop = 1; pr = 1;
    @(negedge clk); check("sim_rdy", rdy, 1); tick();
    cv = 0; pop = 0;
    @(negedge clk);
    check("sim_crd9", crd, 9);
    check("sim_out", outs, 248);
    tick(); pr = 0;

    // Reset while a PHY command is waiting
    do_reset();
    cv = 1; len = 5;
    @(negedge clk); check("midrst_rdy", rdy, 1); tick();
    cv = 0;
    @(negedge clk);
    check("midrst_pv", pv, 1);
    check("midrst_crd", crd, 251);
    rst = 1; tick(); rst = 0;
    @(negedge clk);
    check("midrst_pv0", pv, 0);
    check("midrst_crd256", crd, 256);
    check("midrst_out0", outs, 0);
    tick();

`ifdef RD_RETURN_TIMEOUT_EN
    // Timeout: a burst of 4 that never returns data
    do_reset();
    issue_cmd(4'd4);
    @(negedge clk);
    check("tmo_pre", tmo, 0);
    check("tmo_pre_out", outs, 4);
    tick();
    begin
      bit seen = 0;
      for (int c = 0; c < 1200 && !seen; c++) begin
        @(negedge clk);
        if (tmo) seen = 1;
        tick();
      end
      check("tmo_seen", seen, 1);
    end
    @(negedge clk);
    check("tmo_err", tmo, 1);
    check("tmo_out", outs, 0);
    check("tmo_crd", crd, 256);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
